// File: rtl/phy_rx_pkg.sv
// phy_rx shared types: symbol defaults,
// lane-state and symbol-class encodings.
package phy_rx_pkg;

  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] IDLE_SYM = 8'h7C;

  typedef enum logic [1:0] {
    HUNT,
    COUNT,
    ACTIVE
  } lane_st_e;

  typedef enum logic [1:0] {
    CLS_COM,
    CLS_IDLE,
    CLS_DATA
  } sym_cls_e;

  function automatic sym_cls_e classify(
    input logic [7:0] s,
    input logic [7:0] com,
    input logic [7:0] idle
  );
    sym_cls_e c;
    c = CLS_DATA;
    if (s == com) c = CLS_COM;
    else if (s == idle) c = CLS_IDLE;
    return c;
  endfunction

endpackage

// File: rtl/phy_rx_lane.sv
// One receive lane: deserialiser, COM
// alignment FSM and symbol classifier.
module phy_rx_lane
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM  = COM_SYM,
  parameter logic [7:0] IDLE = IDLE_SYM,
  parameter int ALIGN_COUNT  = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       bit_i,
  output logic [7:0] sym_o,
  output sym_cls_e   cls_o,
  output logic       stb_o,
  output logic       act_o
);

  localparam int HW = $clog2(ALIGN_COUNT + 1);
  localparam logic [HW-1:0] ACNT = HW'(ALIGN_COUNT);

  logic [7:0]    shift_q, shift_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [HW-1:0] hits_q, hits_d;
  lane_st_e      st_q, st_d;
  logic          bnd;

  assign shift_d = {shift_q[6:0], bit_i};
  assign bnd     = (cnt_q == 3'd7);

  // alignment: hunt any bit offset, then
  // confirm COMs on symbol boundaries
  always_comb begin
    st_d   = st_q;
    hits_d = hits_q;
    cnt_d  = cnt_q + 3'd1;
    unique case (st_q)
      HUNT: begin
        if (shift_d == COM) begin
          cnt_d  = 3'd0;
          hits_d = HW'(1);
          st_d   = (ACNT == HW'(1)) ? ACTIVE : COUNT;
        end
      end
      COUNT: begin
        if (bnd) begin
          if (shift_d == COM) begin
            hits_d = hits_q + HW'(1);
            if (hits_d == ACNT) st_d = ACTIVE;
          end else begin
            hits_d = '0;
            st_d   = HUNT;
          end
        end
      end
      ACTIVE: begin
      end
      default: st_d = HUNT;
    endcase
  end

  // lane state registers
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      hits_q  <= '0;
      st_q    <= HUNT;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hits_q  <= hits_d;
      st_q    <= st_d;
    end
  end

  // symbol is seen on the edge shifting
  // in its last bit; top registers it
  assign sym_o = shift_d;
  assign cls_o = classify(shift_d, COM, IDLE);
  assign stb_o = (st_q == ACTIVE) && bnd;
  assign act_o = (st_q == ACTIVE);

endmodule

// File: rtl/phy_rx_lanes.sv
// N-lane PHY receive path and unstriper.
// Optional err_cnt: PHY_RX_ERRCNT_EN.
module phy_rx_lanes
  import phy_rx_pkg::*;
#(
  parameter int LANES          = 2,
  parameter int BYTES_PER_WORD = 4,
  parameter logic [7:0] COM    = COM_SYM,
  parameter logic [7:0] IDLE   = IDLE_SYM,
  parameter int ALIGN_COUNT    = 4
) (
  input  logic                        clk_32f,
  input  logic                        reset,
  input  logic [LANES-1:0]            data_in,
  output logic [8*BYTES_PER_WORD-1:0] data_out,
  output logic                        valid_out,
  output logic                        active_out,
  output logic                        err_out
`ifdef PHY_RX_ERRCNT_EN
  ,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int TPW = BYTES_PER_WORD / LANES;
  localparam int CW  = $clog2(TPW) + 1;
  localparam int W   = 8 * BYTES_PER_WORD;

  logic [7:0]         sym [LANES];
  sym_cls_e           cls [LANES];
  logic [LANES-1:0]   stb, act, is_data;
  logic [8*LANES-1:0] tbytes;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    phy_rx_lane #(
      .COM         (COM),
      .IDLE        (IDLE),
      .ALIGN_COUNT (ALIGN_COUNT)
    ) u_lane (
      .clk_32f (clk_32f),
      .reset   (reset),
      .bit_i   (data_in[g]),
      .sym_o   (sym[g]),
      .cls_o   (cls[g]),
      .stb_o   (stb[g]),
      .act_o   (act[g])
    );
    assign is_data[g] = (cls[g] == CLS_DATA);
    assign tbytes[8*(LANES-1-g) +: 8] = sym[g];
  end

  logic [W-1:0]  acc_q, acc_d, dout_q, dout_d;
  logic [W-1:0]  tick_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          act_q;
  logic          tick, all_data, all_ctl;

  assign tick     = stb[0] && act_q;
  assign all_data = &is_data;
  assign all_ctl  = ~|is_data;

  // unstriper: lane 0 first, MSB first;
  // control-only ticks are skipped
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    tick_w = '0;
    tick_w[8*LANES-1:0] = tbytes;
    if (tick) begin
      unique case (1'b1)
        all_data: begin
          acc_d = (acc_q << (8 * LANES)) | tick_w;
          if (cnt_q == CW'(TPW - 1)) begin
            dout_d = acc_d;
            vld_d  = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        all_ctl: begin
        end
        default: begin
          acc_d = '0;
          cnt_d = '0;
          err_d = 1'b1;
        end
      endcase
    end
  end

  // word, strobe and status registers
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      act_q  <= &act;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vld_q;
  assign active_out = act_q;
  assign err_out    = err_q;

`ifdef PHY_RX_ERRCNT_EN
  logic [7:0] ecnt_q;

  // saturating striping-error count
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) ecnt_q <= '0;
    else if (err_d && ecnt_q != 8'hFF)
      ecnt_q <= ecnt_q + 8'd1;
  end

  assign err_cnt = ecnt_q;
`endif

endmodule

// File: tb/tb_phy_rx_lanes.sv
// Directed scoreboard bench for phy_rx_lanes
// in 2-lane/4B and 4-lane/8B builds.
module tb_phy_rx_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  d2;
  logic [3:0]  d4;
  logic [31:0] data2;
  logic [63:0] data4;
  logic        v2, a2, e2;
  logic        v4, a4, e4;
`ifdef PHY_RX_ERRCNT_EN
  logic [7:0]  ec2, ec4;
`endif

  phy_rx_lanes #(.LANES(2), .BYTES_PER_WORD(4)) u_dut2 (
    .clk_32f    (clk),
    .reset      (rst_n),
    .data_in    (d2),
    .data_out   (data2),
    .valid_out  (v2),
    .active_out (a2),
    .err_out    (e2)
`ifdef PHY_RX_ERRCNT_EN
    ,
    .err_cnt    (ec2)
`endif
  );

  phy_rx_lanes #(.LANES(4), .BYTES_PER_WORD(8)) u_dut4 (
    .clk_32f    (clk),
    .reset      (rst_n),
    .data_in    (d4),
    .data_out   (data4),
    .valid_out  (v4),
    .active_out (a4),
    .err_out    (e4)
`ifdef PHY_RX_ERRCNT_EN
    ,
    .err_cnt    (ec4)
`endif
  );

  localparam logic [15:0] C2 = 16'hBCBC;
  localparam logic [15:0] I2 = 16'h7C7C;
  localparam logic [31:0] C4 = 32'hBCBCBCBC;
  localparam logic [31:0] I4 = 32'h7C7C7C7C;
  localparam logic [31:0] Z4 = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vt2 = 0;
  int en2 = 0;
  int vt4 [$];
  logic [63:0] q2 [$];
  logic [63:0] q4 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (v2 || e2) chk("excl2", {63'b0, v2 & e2}, 64'd0);
    if (v4 || e4) chk("excl4", {63'b0, v4 & e4}, 64'd0);
    if (e2) en2++;
    if (v2) begin
      chk("q2_pending", {63'b0, q2.size() != 0}, 64'd1);
      if (q2.size() != 0) chk("word2", {32'b0, data2}, q2.pop_front());
      vt2 = cyc;
    end
    if (v4) begin
      chk("q4_pending", {63'b0, q4.size() != 0}, 64'd1);
      if (q4.size() != 0) chk("word4", data4, q4.pop_front());
      vt4.push_back(cyc);
    end
  end

  task automatic sym(input logic [15:0] s2, input logic [31:0] s4);
    for (int b = 7; b >= 0; b--) begin
      for (int i = 0; i < 2; i++) d2[i] = s2[8*(1-i)+b];
      for (int i = 0; i < 4; i++) d4[i] = s4[8*(3-i)+b];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && (q2.size() != 0 || q4.size() != 0); k++)
      sym(I2, I4);
    chk("drain2", 64'(q2.size()), 64'd0);
    chk("drain4", 64'(q4.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int e0;
    rst_n = 1'b0;
    d2 = '0;
    d4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data2", {32'b0, data2}, 64'd0);
    chk("rst_valid2", {63'b0, v2}, 64'd0);
    chk("rst_active2", {63'b0, a2}, 64'd0);
    chk("rst_err2", {63'b0, e2}, 64'd0);
    chk("rst_data4", data4, 64'd0);
    chk("rst_active4", {63'b0, a4}, 64'd0);
`ifdef PHY_RX_ERRCNT_EN
    chk("rst_errcnt", {56'b0, ec2}, 64'd0);
`endif
    rst_n = 1'b1;

    sym(C2, Z4);
    sym(16'h0000, Z4);
    sym(C2, Z4);
    sym(C2, Z4);
    sym(C2, Z4);
    chk("falselock_act", {63'b0, a2}, 64'd0);
    sym(C2, Z4);
    c0 = cyc;
    q2.push_back(64'h11223344);
    sym(16'h1122, Z4);
    chk("act_after_lock", {63'b0, a2}, 64'd1);
    sym(16'h3344, Z4);
    drain();
    chk("latency16", 64'(vt2 - c0), 64'd16);

    c0 = cyc;
    q2.push_back(64'h11223344);
    sym(16'h1122, Z4);
    sym(I2, Z4);
    sym(I2, Z4);
    sym(16'h3344, Z4);
    drain();
    chk("latency_idle", 64'(vt2 - c0), 64'd32);

    e0 = en2;
    sym(16'h557C, Z4);
    chk("err_pulse", {63'b0, e2}, 64'd1);
`ifdef PHY_RX_ERRCNT_EN
    chk("errcnt1", {56'b0, ec2}, 64'd1);
`endif
    sym(16'hAABB, Z4);
    sym(16'h7C55, Z4);
    chk("err_pulse2", {63'b0, e2}, 64'd1);
    chk("err_novalid", {63'b0, v2}, 64'd0);
    q2.push_back(64'h11223344);
    sym(16'h1122, Z4);
    sym(16'h3344, Z4);
    drain();
    chk("err_count", 64'(en2 - e0), 64'd2);
`ifdef PHY_RX_ERRCNT_EN
    repeat (298) sym(16'h557C, Z4);
    chk("errcnt_sat", {56'b0, ec2}, 64'hFF);
`endif

    sym(16'h1122, Z4);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", {32'b0, data2}, 64'd0);
    chk("midrst_valid", {63'b0, v2}, 64'd0);
    chk("midrst_active", {63'b0, a2}, 64'd0);
    chk("midrst_err", {63'b0, e2}, 64'd0);
`ifdef PHY_RX_ERRCNT_EN
    chk("midrst_errcnt", {56'b0, ec2}, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sym(16'h3344, Z4);
    sym(I2, Z4);
    chk("rst_noactive", {63'b0, a2}, 64'd0);

    sym(C2, Z4);
    sym(C2, Z4);
    sym(C2, Z4);
    chk("align3_act", {63'b0, a2}, 64'd0);
    sym(C2, Z4);
    q2.push_back(64'h11223344);
    sym(16'h1122, Z4);
    chk("align4_act", {63'b0, a2}, 64'd1);
    sym(16'h3344, Z4);
    drain();

    sym(I2, C4);
    sym(I2, C4);
    sym(I2, C4);
    chk("l4_act3", {63'b0, a4}, 64'd0);
    sym(I2, C4);
    vt4.delete();
    c0 = cyc;
    q4.push_back(64'h0102030405060708);
    q4.push_back(64'h090A0B0C0D0E0F10);
    sym(I2, 32'h01020304);
    chk("l4_act", {63'b0, a4}, 64'd1);
    sym(I2, 32'h05060708);
    sym(I2, 32'h090A0B0C);
    sym(I2, 32'h0D0E0F10);
    drain();
    chk("l4_nwords", 64'(vt4.size()), 64'd2);
    if (vt4.size() >= 2) begin
      chk("l4_latency", 64'(vt4[0] - c0), 64'd16);
      chk("l4_spacing", 64'(vt4[1] - vt4[0]), 64'd16);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_rx_lanes.md
# phy_rx_lanes

Parametrised N-lane PHY receive path. It replaces the fixed two-lane, multi-clock receiver with a single-clock datapath running at the serial bit rate. Each lane deserialises, aligns on the COM symbol and classifies control symbols. A common unstriper then reassembles lane bytes into output words with a one-cycle valid strobe. It sits between the serial lane pins and the link-layer word interface.

## Interface
- LANES, 2: number of serial lanes, 1..8
- BYTES_PER_WORD, 4: output word size in bytes; must be a multiple of LANES
- COM, 8'hBC: alignment/comma symbol
- IDLE, 8'h7C: idle filler symbol
- ALIGN_COUNT, 4: consecutive on-boundary COMs required to declare a lane active

- clk_32f  in  1  serial bit clock, rising edge; only clock in the block
- reset  in  1  asynchronous, active-low
- data_in  in  LANES  one serial bit per lane, MSB of each symbol first
- data_out  out  8*BYTES_PER_WORD  reassembled word; first received byte in the most significant byte
- valid_out  out  1  one-cycle strobe; data_out is valid in that cycle
- active_out  out  1  all lanes in the ACTIVE state
- err_out  out  1  one-cycle strobe on a striping error
- err_cnt  out  8  saturating striping-error count; present only with PHY_RX_ERRCNT_EN

## Operation
- Per-lane FSM:
  - HUNT: the 8-bit shift register is compared with COM on every clock. On a match, the bit counter is cleared and the FSM moves to COUNT with hits=1.
  - COUNT: the symbol is checked only on each boundary (every 8 clocks). COM increments hits; any other symbol returns the lane to HUNT. When hits reaches ALIGN_COUNT, the FSM moves to ACTIVE.
  - ACTIVE: a symbol is emitted every 8 clocks and classified as COM, IDLE or DATA. The lane stays in ACTIVE until reset.
- Unstriping uses lane 0's boundary strobe as the common symbol tick. Lanes must be boundary-aligned; skew is not corrected.
- On each tick with active_out=1:
  - All lanes DATA: append LANES bytes in lane order 0..LANES-1 to the word accumulator.
  - All lanes COM or IDLE: nothing is appended and the partial word is kept.
  - Mixed DATA and control: the partial word is discarded, err_out pulses and the byte count is cleared.
- When the accumulator holds BYTES_PER_WORD bytes, the word is loaded into data_out, valid_out pulses and the count returns to 0.
- data_out holds its last value between strobes.
- Byte count width is clog2(BYTES_PER_WORD/LANES)+1 and wraps to 0 only on word completion or error.

## Timing
- Reset values: data_out=0, valid_out=0, active_out=0, err_out=0, err_cnt=0. All lanes start in HUNT with shift registers and counters at 0.
- Reset asserted mid-word: everything returns to reset values immediately. The partial word is lost with no strobe.
- Symbol capture: the symbol is complete at the clock edge that shifts in its 8th bit. Classification is registered on that edge.
- Word latency: valid_out asserts in the cycle following the edge that shifted in the last bit of the word's final symbol tick.
- active_out rises one cycle after the last lane enters ACTIVE.
- err_out and valid_out never assert in the same cycle. An error tick suppresses completion.
- Minimum spacing between valid_out strobes: 8*BYTES_PER_WORD/LANES clocks.

## Configuration
- PHY_RX_ERRCNT_EN
  - Defined: err_cnt port and register exist. The counter increments on every err_out and saturates at 8'hFF; reset clears it.
  - Undefined: the port and register are absent. err_out behaviour is unchanged.

## Structure
- Shared package/header phy_rx_pkg holds the COM and IDLE defaults, the lane-state encoding (HUNT, COUNT, ACTIVE) and the symbol-class encoding (COM, IDLE, DATA).
- Sub-module phy_rx_lane contains one lane's shift register, bit counter, alignment FSM and classifier. It outputs symbol, class, boundary strobe and active.
- phy_rx_lanes instantiates LANES copies of phy_rx_lane with a generate loop and contains the unstriper and output registers.

## Test plan
- Alignment (LANES=2, BYTES_PER_WORD=4): send 4 COMs per lane, then bytes 0x11,0x33 on lane 0 and 0x22,0x44 on lane 1. Expect active_out=1 after the 4th COM, then one valid_out pulse with data_out=32'h11223344.
- False lock: send a COM, then 0x00, then 4 COMs. The lane returns to HUNT after 0x00 and active_out rises only after the 4 later COMs.
- IDLE filtering: insert two IDLE ticks between the first and second DATA ticks of a word. Expect the same single word 32'h11223344, delayed by 16 clocks.
- Striping error: lane 0 sends DATA and lane 1 sends IDLE on one tick. Expect an err_out pulse, no valid_out, and a correct following word. With PHY_RX_ERRCNT_EN, expect err_cnt=1; after 300 errors, err_cnt=8'hFF.
- Reset mid-word: drop reset after the first DATA tick. All outputs read 0 immediately, and no word emerges until realignment completes.
- Generality (LANES=4, BYTES_PER_WORD=8): send DATA ticks 0x01..0x04, then 0x05..0x08. Expect data_out=64'h0102030405060708, with strobes 16 clocks apart under continuous data.
